nco_poly: RTL

- Time-multiplexed polyphonic NCO; successor to the single-voice velocity-scaled NCO.
- Holds VOICES phase accumulators in one register file.
- On each sample strobe, issues per-voice wavetable phases and velocity-scales the returned samples.
- Sums them into one mixed sample for the output DAC path.
- Sits between the MIDI/voice allocator (config port) and the shared wavetable ROM/RAM.

---
 rtl/nco_poly.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nco_poly.sv
// Time-multiplexed polyphonic NCO: issues one wavetable read per voice per frame and mixes velocity-scaled samples.
// Define NCO_POLY_SATURATE_EN for a saturating sum instead of the divide-by-voice-count mix.
module nco_poly #(
  parameter int VOICES = 4,
  parameter int PW     = 16,
  parameter int TW     = 8,
  parameter int SW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic                       TRIG_SAMPLE,
  input  logic                       CFG_WE,
  input  logic [$clog2(VOICES)-1:0]  CFG_VOICE,
  input  logic [PW-1:0]              CFG_STEP,
  input  logic [6:0]                 CFG_VEL,
  input  logic                       CFG_GATE,
  output logic [TW-1:0]              PHASE_OUT,
  output logic [$clog2(VOICES)-1:0]  PHASE_VOICE,
  output logic                       PHASE_VALID,
  input  logic [SW-1:0]              SAMPLE_IN,
  output logic [SW-1:0]              MIX_OUT,
  output logic                       MIX_VALID,
  output logic                       BUSY,
  output logic                       OVERRUN
);
  localparam int VW = $clog2(VOICES);
  localparam int AW = SW + VW;
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state;
  logic [VW-1:0]              vcnt;
  logic [DW-1:0]              dcnt;
  logic [VOICES-1:0][PW-1:0]  phase, step;
  logic [VOICES-1:0][6:0]     vel;
  logic [VOICES-1:0]          gate;
  logic [RD_LAT-1:0]          vld_pipe, gate_pipe;
  logic [RD_LAT-1:0][6:0]     vel_pipe;
  logic [AW-1:0]              acc, acc_next;
  logic [SW+6:0]              prod;
  logic [SW-1:0]              scaled, mix;
  logic                       issue;

  assign issue       = (state == ISSUE);
  assign PHASE_VOICE = vcnt;
  assign PHASE_OUT   = phase[vcnt][PW-1 -: TW];

  // Tail of the tag pipe lines up with the returning wavetable sample.
  assign prod     = {7'd0, SAMPLE_IN} * {{SW{1'b0}}, vel_pipe[RD_LAT-1]};
  assign scaled   = (vld_pipe[RD_LAT-1] && gate_pipe[RD_LAT-1]) ? SW'(prod >> 7) : '0;
  assign acc_next = acc + {{VW{1'b0}}, scaled};

`ifdef NCO_POLY_SATURATE_EN
  assign mix = (|acc_next[AW-1:SW]) ? {SW{1'b1}} : acc_next[SW-1:0];
`else
  assign mix = acc_next[AW-1:VW];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      vcnt        <= '0;
      dcnt        <= '0;
      acc         <= '0;
      PHASE_VALID <= 1'b0;
      BUSY        <= 1'b0;
      MIX_VALID   <= 1'b0;
      MIX_OUT     <= '0;
      OVERRUN     <= 1'b0;
    end else if (CE) begin
      MIX_VALID <= 1'b0;
      acc       <= acc_next;
      if (TRIG_SAMPLE && BUSY) OVERRUN <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (TRIG_SAMPLE) begin
            state       <= ISSUE;
            vcnt        <= '0;
            acc         <= '0;
            PHASE_VALID <= 1'b1;
            BUSY        <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (vcnt == VW'(VOICES-1)) begin
            state       <= DRAIN;
            dcnt        <= '0;
            PHASE_VALID <= 1'b0;
          end else begin
            vcnt <= vcnt + VW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == DW'(RD_LAT-1)) begin
            state     <= DONE;
            BUSY      <= 1'b0;
            MIX_VALID <= 1'b1;
            MIX_OUT   <= mix;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Config write is ordered after the phase step so it wins on a same-cycle collision.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase <= '0;
      step  <= '0;
      vel   <= '0;
      gate  <= '0;
    end else if (CE) begin
      if (issue && gate[vcnt]) phase[vcnt] <= phase[vcnt] + step[vcnt];
      if (CFG_WE) begin
        step[CFG_VOICE] <= CFG_STEP;
        vel[CFG_VOICE]  <= CFG_VEL;
        gate[CFG_VOICE] <= CFG_GATE;
        if (CFG_GATE && !gate[CFG_VOICE]) phase[CFG_VOICE] <= '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe  <= '0;
      gate_pipe <= '0;
      vel_pipe  <= '0;
    end else if (CE) begin
      vld_pipe[0]  <= issue;
      gate_pipe[0] <= gate[vcnt];
      vel_pipe[0]  <= vel[vcnt];
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        gate_pipe[k] <= gate_pipe[k-1];
        vel_pipe[k]  <= vel_pipe[k-1];
      end
    end
  end
endmodule
